// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator controller:
// FSM state encoding, recorded-result encoding and a flag decode helper.
package serial_cmp_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_LT = 2'd1;
  localparam logic [1:0] RES_GT = 2'd2;

  // Decode a recorded result into the one-hot {eq, lt, gt} flag triple.
  function automatic logic [2:0] res_to_flags(input logic [1:0] res);
    logic [2:0] flags;
    case (res)
      RES_LT:  flags = 3'b010;
      RES_GT:  flags = 3'b001;
      default: flags = 3'b100;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/serial_mag_compare_ctrl_if.sv
// Operand/result handshake bundle for serial_mag_compare_ctrl.
// slave: the controller side. master: the operand source / result sink side.
interface serial_mag_compare_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic             AeB;
  logic             AlB;
  logic             AgB;

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, AeB, AlB, AgB
  );

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, AeB, AlB, AgB
  );

endinterface

// File: rtl/serial_mag_compare_ctrl_cell.sv
// Single-bit magnitude comparator cell shared across all bit positions.
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic lt,
  output logic gt
);

  assign eq = ~(a ^ b);
  assign lt = ~a & b;
  assign gt = a & ~b;

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude comparator controller: walks one shared 1-bit cell from
// MSB to LSB over two registered operands and reports one-hot EQ/LT/GT.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: leave SCAN on the first differing
// bit instead of always scanning all WIDTH bits.
module serial_mag_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_mag_compare_ctrl_if.slave  bus,
  output logic                      busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       res_q;
  logic             decided_q;
  logic             out_valid_q;
  logic [2:0]       flags_q;

  logic cell_a, cell_b;
  logic cell_eq, cell_lt, cell_gt;
  logic [1:0] scan_res;
  logic scan_done;

  // The cell only sees real data while scanning and before a difference is
  // recorded; otherwise its inputs sit at 0 so it never toggles.
  assign cell_a = (state == SCAN) && !decided_q && a_q[idx];
  assign cell_b = (state == SCAN) && !decided_q && b_q[idx];

  bit_cmp_cell u_cell (
    .a  (cell_a),
    .b  (cell_b),
    .eq (cell_eq),
    .lt (cell_lt),
    .gt (cell_gt)
  );

  // Result after this SCAN cycle: the first recorded difference always wins.
  always_comb begin
    scan_res = res_q;
    if (!decided_q) begin
      if (cell_gt)
        scan_res = RES_GT;
      else if (cell_lt)
        scan_res = RES_LT;
    end
  end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign scan_done = (idx == '0) || !cell_eq;
`else
  assign scan_done = (idx == '0);
`endif

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.AeB       = flags_q[2];
  assign bus.AlB       = flags_q[1];
  assign bus.AgB       = flags_q[0];
  assign busy          = (state == SCAN);

  // Controller FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= RES_EQ;
      decided_q   <= 1'b0;
      out_valid_q <= 1'b0;
      flags_q     <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q       <= bus.A;
            b_q       <= bus.B;
            idx       <= IDX_TOP;
            res_q     <= RES_EQ;
            decided_q <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          res_q <= scan_res;
          if (!cell_eq)
            decided_q <= 1'b1;
          if (scan_done) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
            flags_q     <= res_to_flags(scan_res);
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            flags_q     <= 3'b000;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          flags_q     <= 3'b000;
        end
      endcase
    end
  end

endmodule
